bcd_counter4: RTL and testbench

- 4-digit BCD up/down counter that produces the count0..count3 digit values consumed directly by sseg_driver.
- An internal prescaler sets the step rate, so the displayed value advances at a visible rate from the board clock.
- Supports enable, direction, and synchronous parallel load, and flags wrap-around with a pulse.

---
 rtl/bcd_counter4.sv | 107 ++++++++++
 tb/tb_bcd_counter4.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter4.sv
// 4-digit BCD up/down counter with prescaled step rate, parallel load and wrap pulse.
// Optional build macro BCD_COUNTER_SATURATE_EN: saturate at 9999/0000 instead of wrapping.
module bcd_counter4 #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  count0,
  output logic [3:0]  count1,
  output logic [3:0]  count2,
  output logic [3:0]  count3,
  output logic        tick,
  output logic        wrap
);

  localparam int              PRE_W   = $clog2(TICK_DIV) + 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [3:0][3:0]  cur;
  logic [3:0][3:0]  nxt;
  logic             carry;
  logic             wrap_nxt;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign cur = {count3, count2, count1, count0};

  // Ripple the carry/borrow from digit0 upward; a carry out of digit3 means the
  // whole counter rolled over.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    nxt      = cur;
    carry    = 1'b1;
    wrap_nxt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (up) begin
          if (cur[i] == 4'd9) begin
            nxt[i] = 4'd0;
          end else begin
            nxt[i] = cur[i] + 4'd1;
            carry  = 1'b0;
          end
        end else begin
          if (cur[i] == 4'd0) begin
            nxt[i] = 4'd9;
          end else begin
            nxt[i] = cur[i] - 4'd1;
            carry  = 1'b0;
          end
        end
      end
    end
`ifdef BCD_COUNTER_SATURATE_EN
    if (carry) begin
      nxt = cur;
    end
`else
    wrap_nxt = carry;
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; reset here is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre    <= '0;
      count0 <= 4'd0;
      count1 <= 4'd0;
      count2 <= 4'd0;
      count3 <= 4'd0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (load) begin
      pre    <= '0;
      count0 <= clamp_bcd(load_val[3:0]);
      count1 <= clamp_bcd(load_val[7:4]);
      count2 <= clamp_bcd(load_val[11:8]);
      count3 <= clamp_bcd(load_val[15:12]);
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (en && (pre == PRE_MAX)) begin
      pre    <= '0;
      count0 <= nxt[0];
      count1 <= nxt[1];
      count2 <= nxt[2];
      count3 <= nxt[3];
      tick   <= 1'b1;
      wrap   <= wrap_nxt;
    end else begin
      // Disabled cycles keep the prescaler phase so the interval resumes where it stopped.
      if (en) begin
        pre <= pre + 1'b1;
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed self-checking bench for bcd_counter4 with TICK_DIV = 4.
// Honors BCD_COUNTER_SATURATE_EN when the design is built with it.
module tb_bcd_counter4;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  count0, count1, count2, count3;
  logic        tick;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  bcd_counter4 #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count0   (count0),
    .count1   (count1),
    .count2   (count2),
    .count3   (count3),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {count3, count2, count1, count0};
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string name, input logic [15:0] exp);
    checks++;
    if (digits() !== exp) begin
      errors++;
      $display("FAIL %s: digits=%h expected=%h", name, digits(), exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic exp_tick, input logic exp_wrap);
    checks++;
    if ({tick, wrap} !== {exp_tick, exp_wrap}) begin
      errors++;
      $display("FAIL %s: tick/wrap=%b%b expected=%b%b", name, tick, wrap, exp_tick, exp_wrap);
    end
  endtask

  // One full enabled interval from prescaler phase 0: no pulse for TICK_DIV-1 edges,
  // then the step is presented with tick=1.
  task automatic run_interval(input string name, input logic [15:0] exp_val, input logic exp_wrap);
    for (int i = 0; i < TICK_DIV - 1; i++) begin
      edge1();
      chk_flags({name, "_idle"}, 1'b0, 1'b0);
    end
    edge1();
    chk_val(name, exp_val);
    chk_flags({name, "_pulse"}, 1'b1, exp_wrap);
  endtask

  task automatic do_load(input string name, input logic [15:0] val, input logic [15:0] exp);
    load     = 1'b1;
    load_val = val;
    edge1();
    load     = 1'b0;
    chk_val(name, exp);
    chk_flags({name, "_flags"}, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 16'h0;
    repeat (2) begin
      edge1();
      chk_val("reset_digits", 16'h0000);
      chk_flags("reset_flags", 1'b0, 1'b0);
    end
    reset = 1'b1;
    run_interval("first_step", 16'h0001, 1'b0);
    run_interval("second_step", 16'h0002, 1'b0);
  endtask

  task automatic test_carry_up();
    up = 1'b1;
    do_load("load_0999", 16'h0999, 16'h0999);
    run_interval("carry_1000", 16'h1000, 1'b0);
  endtask

  task automatic test_wrap_up();
    up = 1'b1;
    do_load("load_9999", 16'h9999, 16'h9999);
`ifdef BCD_COUNTER_SATURATE_EN
    run_interval("sat_up", 16'h9999, 1'b0);
`else
    run_interval("wrap_up", 16'h0000, 1'b1);
`endif
    edge1();
    chk_flags("wrap_up_one_cycle", 1'b0, 1'b0);
  endtask

  task automatic test_wrap_down();
    up = 1'b0;
    do_load("load_0000", 16'h0000, 16'h0000);
`ifdef BCD_COUNTER_SATURATE_EN
    run_interval("sat_down", 16'h0000, 1'b0);
`else
    run_interval("wrap_down", 16'h9999, 1'b1);
`endif
    do_load("load_0100", 16'h0100, 16'h0100);
    run_interval("borrow_0099", 16'h0099, 1'b0);
  endtask

  task automatic test_enable_pause();
    up = 1'b1;
    do_load("pause_load", 16'h0000, 16'h0000);
    repeat (2) edge1();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk_flags("pause_no_tick", 1'b0, 1'b0);
    end
    chk_val("pause_hold", 16'h0000);
    en = 1'b1;
    edge1();
    chk_flags("resume_first", 1'b0, 1'b0);
    edge1();
    chk_val("resume_step", 16'h0001);
    chk_flags("resume_pulse", 1'b1, 1'b0);
  endtask

  task automatic test_load_collision();
    up = 1'b1;
    do_load("coll_pre_load", 16'h0000, 16'h0000);
    repeat (TICK_DIV - 1) edge1();
    do_load("coll_load_12AF", 16'h12AF, 16'h1299);
    run_interval("coll_restart", 16'h1300, 1'b0);
    reset = 1'b0;
    do_load("reset_over_load", 16'h5555, 16'h0000);
    reset = 1'b1;
    run_interval("post_reset_step", 16'h0001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_carry_up();
    test_wrap_up();
    test_wrap_down();
    test_enable_pause();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
